// File: rtl/hpi_txn_sequencer.sv
// CY7C67200 HPI transaction master: turns direct-register and memory commands
// into timed cs/r/w sequences on the pad interface's from_sw_* side.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | cmd_ready high, waiting for a command
// S_SETUP   | cs low, address and write data driven, strobes high
// S_STROBE  | r or w low for STROBE_CYCLES
// S_HOLD    | strobes high, cs low; 1 cycle for writes, 2 for reads
// S_RECOVER | cs high between the HPI_ADDRESS access and the data access
// S_DONE    | cs high after the final access; rsp_valid on its first cycle
module hpi_txn_sequencer #(
   parameter int STROBE_CYCLES  = 4,
   parameter int RECOVER_CYCLES = 2,
   parameter bit ADDR_CACHE_EN  = 1'b1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_mem,
   input  logic [1:0]  cmd_reg,
   input  logic [15:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic [1:0]  from_sw_address,
   output logic [15:0] from_sw_data_out,
   input  logic [15:0] from_sw_data_in,
   output logic        from_sw_r,
   output logic        from_sw_w,
   output logic        from_sw_cs
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER, S_DONE
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_addr_phase;
   logic        r_acc_write;
   logic        r_write;
   logic        r_mem;
   logic [1:0]  r_reg;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_cache_addr;
   logic        r_cache_valid;
   logic        w_hit;

   // The chip's HPI_ADDRESS auto-increments by 2 after every HPI_DATA access.
   assign w_hit = ADDR_CACHE_EN && r_cache_valid && (cmd_addr == r_cache_addr);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state          <= S_IDLE;
         r_cnt            <= 4'd0;
         r_addr_phase     <= 1'b0;
         r_acc_write      <= 1'b0;
         r_write          <= 1'b0;
         r_mem            <= 1'b0;
         r_reg            <= 2'd0;
         r_addr           <= 16'h0000;
         r_wdata          <= 16'h0000;
         r_cache_addr     <= 16'h0000;
         r_cache_valid    <= 1'b0;
         cmd_ready        <= 1'b0;
         rsp_valid        <= 1'b0;
         rsp_rdata        <= 16'h0000;
         from_sw_address  <= 2'd0;
         from_sw_data_out <= 16'h0000;
         from_sw_r        <= 1'b1;
         from_sw_w        <= 1'b1;
         from_sw_cs       <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!cmd_ready) begin
                  cmd_ready <= 1'b1;
               end else if (cmd_valid) begin
                  cmd_ready  <= 1'b0;
                  r_state    <= S_SETUP;
                  from_sw_cs <= 1'b0;
                  r_write    <= cmd_write;
                  r_mem      <= cmd_mem;
                  r_reg      <= cmd_reg;
                  r_addr     <= cmd_addr;
                  r_wdata    <= cmd_wdata;
                  if (cmd_mem && !w_hit) begin
                     r_addr_phase     <= 1'b1;
                     r_acc_write      <= 1'b1;
                     from_sw_address  <= 2'd2;
                     from_sw_data_out <= cmd_addr;
                  end else begin
                     r_addr_phase     <= 1'b0;
                     r_acc_write      <= cmd_write;
                     from_sw_address  <= cmd_mem ? 2'd0 : cmd_reg;
                     from_sw_data_out <= cmd_write ? cmd_wdata : 16'h0000;
                  end
               end
            end
            S_SETUP: begin
               r_state   <= S_STROBE;
               r_cnt     <= 4'(STROBE_CYCLES - 1);
               from_sw_r <= r_acc_write;
               from_sw_w <= !r_acc_write;
            end
            S_STROBE: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state   <= S_HOLD;
                  from_sw_r <= 1'b1;
                  from_sw_w <= 1'b1;
                  // Reads hold one extra cycle to cover the two pad register stages.
                  r_cnt     <= r_acc_write ? 4'd0 : 4'd1;
               end
            end
            S_HOLD: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  from_sw_cs <= 1'b1;
                  r_cnt      <= 4'(RECOVER_CYCLES - 1);
                  if (!r_acc_write) begin
                     rsp_rdata <= from_sw_data_in;
                  end
                  if (r_addr_phase) begin
                     r_state <= S_RECOVER;
                  end else begin
                     r_state   <= S_DONE;
                     rsp_valid <= 1'b1;
                     if (r_mem) begin
                        r_cache_addr  <= r_addr + 16'd2;
                        r_cache_valid <= 1'b1;
                     end else if (r_reg == 2'd2 && r_write) begin
                        r_cache_addr  <= r_wdata;
                        r_cache_valid <= 1'b1;
                     end else if (r_reg == 2'd0) begin
                        r_cache_valid <= 1'b0;
                     end
                  end
               end
            end
            S_RECOVER: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state          <= S_SETUP;
                  from_sw_cs       <= 1'b0;
                  r_addr_phase     <= 1'b0;
                  r_acc_write      <= r_write;
                  from_sw_address  <= 2'd0;
                  from_sw_data_out <= r_write ? r_wdata : 16'h0000;
               end
            end
            S_DONE: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state   <= S_IDLE;
                  cmd_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hpi_txn_sequencer.sv
// Bench for hpi_txn_sequencer: pad/chip model, schedule-based reference model
// checked every cycle, plus directed commands with literal latency expectations.
module tb_hpi_txn_sequencer;

   localparam int S = 4;
   localparam int R = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        cmd_valid, cmd_ready, cmd_write, cmd_mem;
   logic [1:0]  cmd_reg;
   logic [15:0] cmd_addr, cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [1:0]  from_sw_address;
   logic [15:0] from_sw_data_out;
   logic [15:0] from_sw_data_in = 16'h0000;
   logic        from_sw_r, from_sw_w, from_sw_cs;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   hpi_txn_sequencer #(.STROBE_CYCLES(S), .RECOVER_CYCLES(R), .ADDR_CACHE_EN(1'b1)) dut (
      .Clk(Clk), .Reset(Reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_mem(cmd_mem), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .from_sw_address(from_sw_address), .from_sw_data_out(from_sw_data_out),
      .from_sw_data_in(from_sw_data_in),
      .from_sw_r(from_sw_r), .from_sw_w(from_sw_w), .from_sw_cs(from_sw_cs)
   );

   always #5 Clk = ~Clk;

   // Pad: one register stage out, one back in; the chip drives data only while
   // it sees r and cs low.
   logic [15:0] rd_value = 16'h0000;
   logic        pad_r  = 1'b1;
   logic        pad_cs = 1'b1;
   always @(posedge Clk) begin
      pad_r           <= from_sw_r;
      pad_cs          <= from_sw_cs;
      from_sw_data_in <= (!pad_r && !pad_cs) ? rd_value : 16'h0000;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int alen(input bit wr);
      return wr ? S + 2 : S + 3;
   endfunction

   // Reference model: on accept, lay out the command as a list of accesses on
   // absolute cycle numbers; outputs follow from where the current cycle falls.
   bit          m_started = 1'b0;
   bit          m_busy    = 1'b0;
   int          m_rsp_at, m_ready_at;
   int          n_acc = 0;
   int          a_start [2];
   logic [1:0]  a_reg   [2];
   bit          a_wr    [2];
   logic [15:0] a_data  [2];
   bit          m_rd;
   logic [15:0] m_rdval;
   logic [15:0] m_rdata = 16'h0000;
   logic [1:0]  m_last  = 2'd0;
   bit          m_cv    = 1'b0;
   logic [15:0] m_ca    = 16'h0000;

   task automatic add_acc(input logic [1:0] rg, input bit wr, input logic [15:0] d);
      a_start[n_acc] = (n_acc == 0) ? cyc + 1 : a_start[0] + alen(a_wr[0]) + R;
      a_reg[n_acc]   = rg;
      a_wr[n_acc]    = wr;
      a_data[n_acc]  = wr ? d : 16'h0000;
      n_acc++;
   endtask

   initial forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
         m_started = 1'b0;
         m_busy    = 1'b0;
         m_cv      = 1'b0;
         m_rdata   = 16'h0000;
         m_last    = 2'd0;
         n_acc     = 0;
      end else begin
         if (m_busy) begin
            if (cyc + 1 == m_ready_at) begin
               m_busy = 1'b0;
               m_last = a_reg[n_acc-1];
               if (m_rd) m_rdata = m_rdval;
            end
         end else if (m_started && cmd_valid) begin
            n_acc = 0;
            if (cmd_mem && !(m_cv && cmd_addr == m_ca)) add_acc(2'd2, 1'b1, cmd_addr);
            add_acc(cmd_mem ? 2'd0 : cmd_reg, cmd_write, cmd_wdata);
            m_rsp_at   = a_start[n_acc-1] + alen(a_wr[n_acc-1]);
            m_ready_at = m_rsp_at + R;
            m_rd       = !cmd_write;
            m_rdval    = rd_value;
            m_busy     = 1'b1;
            if (cmd_mem) begin
               m_ca = cmd_addr + 16'd2;
               m_cv = 1'b1;
            end else if (cmd_reg == 2'd2 && cmd_write) begin
               m_ca = cmd_wdata;
               m_cv = 1'b1;
            end else if (cmd_reg == 2'd0) begin
               m_cv = 1'b0;
            end
         end
         m_started = 1'b1;
         cyc++;
      end
   end

   initial forever begin
      logic        er, ew, ecs, erdy, ersp;
      logic [1:0]  ea;
      logic [15:0] ed, erd;
      bit          dchk;
      @(negedge Clk);
      er = 1'b1; ew = 1'b1; ecs = 1'b1; ed = 16'h0000; dchk = 1'b0;
      if (Reset) begin
         ea = 2'd0; erdy = 1'b0; ersp = 1'b0; erd = 16'h0000; dchk = 1'b1;
      end else begin
         ea   = m_last;
         erdy = m_started && !m_busy;
         ersp = m_busy && cyc == m_rsp_at;
         erd  = (m_busy && m_rd && cyc >= m_rsp_at) ? m_rdval : m_rdata;
         if (m_busy) begin
            for (int k = 0; k < n_acc; k++) begin
               if (cyc >= a_start[k]) ea = a_reg[k];
               if (cyc >= a_start[k] && cyc < a_start[k] + alen(a_wr[k])) begin
                  ecs  = 1'b0;
                  ed   = a_data[k];
                  dchk = 1'b1;
                  if (cyc >= a_start[k] + 1 && cyc <= a_start[k] + S) begin
                     if (a_wr[k]) ew = 1'b0;
                     else         er = 1'b0;
                  end
               end
            end
         end
      end
      chk("cmp_r",     16'(from_sw_r),  16'(er));
      chk("cmp_w",     16'(from_sw_w),  16'(ew));
      chk("cmp_cs",    16'(from_sw_cs), 16'(ecs));
      chk("cmp_addr",  16'(from_sw_address), 16'(ea));
      chk("cmp_ready", 16'(cmd_ready),  16'(erdy));
      chk("cmp_rsp",   16'(rsp_valid),  16'(ersp));
      chk("cmp_rdata", rsp_rdata, erd);
      if (dchk) chk("cmp_dout", from_sw_data_out, ed);
   end

   task automatic do_cmd(input string name, input bit wr, input bit mem, input logic [1:0] rg,
                         input logic [15:0] ad, input logic [15:0] wd, input logic [15:0] rv,
                         input int exp_lat, input int exp_cs, input int exp_stb);
      int acc = 0, cs_n = 0, stb_n = 0;
      bit got = 1'b0;
      @(posedge Clk); #1;
      rd_value = rv;
      cmd_write = wr; cmd_mem = mem; cmd_reg = rg; cmd_addr = ad; cmd_wdata = wd;
      cmd_valid = 1'b1;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge Clk);
         if (cmd_ready) begin got = 1'b1; acc = cyc; end
      end
      if (!got) begin
         chk_int({name, "_accept_timeout"}, 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge Clk); #1;
      cmd_valid = 1'b0;
      cmd_write = !wr; cmd_mem = !mem; cmd_reg = ~rg; cmd_addr = ~ad; cmd_wdata = ~wd;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge Clk);
         if (rsp_valid) got = 1'b1;
         else begin
            if (!from_sw_cs) cs_n++;
            if (!from_sw_r || !from_sw_w) stb_n++;
         end
      end
      if (!got) begin
         chk_int({name, "_rsp_timeout"}, 0, 1);
         return;
      end
      chk_int({name, "_latency"}, cyc - acc, exp_lat);
      chk_int({name, "_cs_cycles"}, cs_n, exp_cs);
      chk_int({name, "_strobe_cycles"}, stb_n, exp_stb);
      if (!wr) chk({name, "_rdata"}, rsp_rdata, rv);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_c [3];
      int rsp_n;
      bit got;
      Reset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_mem = 1'b0; cmd_reg = 2'd0;
      cmd_addr = 16'h0000; cmd_wdata = 16'h0000;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("reset_cs", 16'(from_sw_cs), 16'h0001);
      chk("reset_ready", 16'(cmd_ready), 16'h0000);
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("ready_before_first_edge", 16'(cmd_ready), 16'h0000);
      @(negedge Clk);
      chk("ready_after_first_edge", 16'(cmd_ready), 16'h0001);

      do_cmd("dwr_reg1",   1, 0, 2'd1, 16'h0000, 16'h1234, 16'h0000, 7, 6, 4);
      do_cmd("drd_reg3",   0, 0, 2'd3, 16'h0000, 16'h0000, 16'hBEEF, 8, 7, 4);
      do_cmd("mwr_1000",   1, 1, 2'd0, 16'h1000, 16'hA5A5, 16'h0000, 15, 12, 8);
      do_cmd("mwr_1002",   1, 1, 2'd0, 16'h1002, 16'h5A5A, 16'h0000, 7, 6, 4);
      do_cmd("mrd_fffe",   0, 1, 2'd0, 16'hFFFE, 16'h0000, 16'h1111, 16, 13, 8);
      do_cmd("mrd_0000",   0, 1, 2'd0, 16'h0000, 16'h0000, 16'h2222, 8, 7, 4);
      do_cmd("drd_reg0",   0, 0, 2'd0, 16'h0000, 16'h0000, 16'h3333, 8, 7, 4);
      do_cmd("mrd_0002",   0, 1, 2'd0, 16'h0002, 16'h0000, 16'h4444, 16, 13, 8);
      do_cmd("dwr_reg2",   1, 0, 2'd2, 16'h0000, 16'h0500, 16'h0000, 7, 6, 4);
      do_cmd("mwr_0500",   1, 1, 2'd0, 16'h0500, 16'hC3C3, 16'h0000, 7, 6, 4);
      do_cmd("mwr_1000b",  1, 1, 2'd0, 16'h1000, 16'h0F0F, 16'h0000, 15, 12, 8);

      // Reset in the middle of a read strobe; 0x1002 would otherwise be a cache hit.
      @(posedge Clk); #1;
      rd_value = 16'h7777;
      cmd_write = 1'b0; cmd_mem = 1'b0; cmd_reg = 2'd1; cmd_valid = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge Clk);
         if (cmd_ready) got = 1'b1;
      end
      @(posedge Clk); #1;
      cmd_valid = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge Clk);
         if (!from_sw_r) got = 1'b1;
      end
      chk_int("midreset_saw_strobe", int'(got), 1);
      @(posedge Clk); #1;
      Reset = 1'b1;
      #1;
      chk("midreset_r_async",  16'(from_sw_r),  16'h0001);
      chk("midreset_cs_async", 16'(from_sw_cs), 16'h0001);
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      rsp_n = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge Clk);
         if (rsp_valid) rsp_n++;
      end
      chk_int("midreset_no_rsp", rsp_n, 0);
      do_cmd("mwr_1002_after_reset", 1, 1, 2'd0, 16'h1002, 16'h6666, 16'h0000, 15, 12, 8);

      // cmd_valid held high across three back-to-back commands.
      @(posedge Clk); #1;
      rd_value  = 16'h9ABC;
      cmd_valid = 1'b1;
      cmd_write = 1'b1; cmd_mem = 1'b0; cmd_reg = 2'd1; cmd_wdata = 16'h1111;
      for (int k = 0; k < 3; k++) begin
         got = 1'b0;
         acc_c[k] = 0;
         for (int n = 0; n < 100 && !got; n++) begin
            @(negedge Clk);
            if (cmd_ready) begin got = 1'b1; acc_c[k] = cyc; end
         end
         if (!got) chk_int("b2b_accept_timeout", k, -1);
         @(posedge Clk); #1;
         if (k == 0) begin cmd_write = 1'b0; cmd_reg = 2'd3; end
         if (k == 1) begin cmd_write = 1'b1; cmd_reg = 2'd1; cmd_wdata = 16'h2222; end
         if (k == 2) cmd_valid = 1'b0;
      end
      chk_int("b2b_gap_after_write", acc_c[1] - acc_c[0], 9);
      chk_int("b2b_gap_after_read",  acc_c[2] - acc_c[1], 10);
      repeat (12) @(negedge Clk);
      chk("b2b_last_rdata", rsp_rdata, 16'h9ABC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
